// File: rtl/rx_capture_pkg.sv
// Shared types and constants for the ADC frame capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_capture_pkg;

  // Header is {frame_cnt[15:0], len[15:0]}; ADC words share the same width.
  localparam int HDR_W       = 32;
  localparam int LEN_W       = 16;
  localparam int FCNT_W      = 16;
  localparam int FIFO_AW_DEF = 4;

  // Capture sequencer: wait for trigger, emit one header, then len samples.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  // One stream beat as stored in the FIFO: end-of-frame marker plus payload.
  typedef struct packed {
    logic             last;
    logic [HDR_W-1:0] dat;
  } word_t;

  localparam int WORD_W = $bits(word_t);

  // Header word layout: frame counter in the upper half, length in the lower.
  function automatic logic [HDR_W-1:0] mk_hdr(input logic [FCNT_W-1:0] fcnt,
                                               input logic [LEN_W-1:0]  len);
    return {fcnt, len};
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO, 2**AW entries of W bits.
// Latency: a written word is visible on rd_dat_o the cycle after the write.
// Backpressure: writes while full are refused unless a pop occurs in the same cycle.
module rx_fifo #(
  parameter int W  = 33,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_dat_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_DEPTH = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_DEPTH);
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle;
  // the freed slot is the one the write pointer already addresses.
  assign pop  = rd_en_i && !empty_o;
  assign push = wr_en_i && (!full_o || pop);

  // Pointer and occupancy next-state; pointers wrap naturally at 2**AW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care until the occupancy covers them.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rx_capture.sv
// Triggered ADC frame capture: header word then rxsmps samples onto an AXI-style stream.
// Latency: trig in cycle k -> header on the stream in k+2; samples from cycles k+2..k+1+len.
// Backpressure: none toward the ADC; words arriving at a full FIFO are dropped and flagged in ovf.
module rx_capture
  import rx_capture_pkg::*;
#(
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic             ref_clk,
  input  logic             ref_rstn,
  input  logic             trig,
  input  logic [LEN_W-1:0] rxsmps,
  input  logic [HDR_W-1:0] adc_0,
  input  logic             clr,
  output logic [HDR_W-1:0] RX_0_tdata,
  output logic             RX_0_tvalid,
  output logic             RX_0_tlast,
  input  logic             RX_0_tready,
  output logic             busy,
  output logic             ovf,
  output logic             trig_miss
);

  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              ovf_q, ovf_d;
  logic              miss_q, miss_d;

  word_t             wr_word;
  logic              wr_en;
  word_t             rd_word;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_cnt;
  logic              drop_ev;
  logic              miss_ev;

  rx_fifo #(
    .W  (WORD_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i    (ref_clk),
    .rst_ni   (ref_rstn),
    .wr_en_i  (wr_en),
    .wr_dat_i (wr_word),
    .rd_en_i  (pop),
    .rd_dat_o (rd_word),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

  assign pop = RX_0_tvalid && RX_0_tready;

  // Sequencer: latch length on trigger, one header cycle, then one sample per cycle.
  // Counting never stalls on the FIFO, so a frame always spans len+1 write cycles.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    wr_en   = 1'b0;
    wr_word = '0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          len_d   = rxsmps;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        wr_en        = 1'b1;
        wr_word.dat  = mk_hdr(fcnt_q, len_q);
        wr_word.last = (len_q == '0);
        fcnt_d       = fcnt_q + FCNT_ONE;
        wcnt_d       = '0;
        state_d      = (len_q == '0) ? ST_IDLE : ST_CAPT;
      end
      ST_CAPT: begin
        wr_en        = 1'b1;
        wr_word.dat  = adc_0;
        wr_word.last = (wcnt_q == len_q - LEN_ONE);
        wcnt_d       = wcnt_q + LEN_ONE;
        if (wr_word.last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a new event in the clear cycle keeps the flag set.
  assign drop_ev = wr_en && fifo_full && !pop;
  assign miss_ev = trig && (state_q != ST_IDLE);

  always_comb begin
    ovf_d  = drop_ev ? 1'b1 : (clr ? 1'b0 : ovf_q);
    miss_d = miss_ev ? 1'b1 : (clr ? 1'b0 : miss_q);
  end

  // State, counters and flags; reset abandons any frame in progress.
  always_ff @(posedge ref_clk or negedge ref_rstn) begin
    if (!ref_rstn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      ovf_q   <= ovf_d;
      miss_q  <= miss_d;
    end
  end

  // Stale FIFO storage is masked so data/last read as zero whenever nothing is queued.
  assign RX_0_tvalid = !fifo_empty;
  assign RX_0_tdata  = (fifo_cnt != '0) ? rd_word.dat : '0;
  assign RX_0_tlast  = (fifo_cnt != '0) ? rd_word.last : 1'b0;
  assign busy        = (state_q != ST_IDLE);
  assign ovf         = ovf_q;
  assign trig_miss   = miss_q;

endmodule

// File: tb/tb_rx_capture.sv
// Directed and randomized checks of rx_capture against a frame-level queue model.
// Latency: n/a (testbench).
// Backpressure: tready driven by the stimulus.
module tb_rx_capture;

  logic        ref_clk = 1'b0;
  logic        ref_rstn;
  logic        trig;
  logic [15:0] rxsmps;
  logic [31:0] adc_0;
  logic        clr;
  logic [31:0] RX_0_tdata;
  logic        RX_0_tvalid;
  logic        RX_0_tlast;
  logic        RX_0_tready;
  logic        busy;
  logic        ovf;
  logic        trig_miss;

  rx_capture #(.FIFO_AW(4)) dut (
    .ref_clk     (ref_clk),
    .ref_rstn    (ref_rstn),
    .trig        (trig),
    .rxsmps      (rxsmps),
    .adc_0       (adc_0),
    .clr         (clr),
    .RX_0_tdata  (RX_0_tdata),
    .RX_0_tvalid (RX_0_tvalid),
    .RX_0_tlast  (RX_0_tlast),
    .RX_0_tready (RX_0_tready),
    .busy        (busy),
    .ovf         (ovf),
    .trig_miss   (trig_miss)
  );

  always #5 ref_clk = ~ref_clk;

  // Pending FIFO write, one per future cycle: header value or "sample of that cycle".
  typedef struct {
    bit          is_hdr;
    bit          last;
    logic [31:0] dat;
  } wr_t;

  localparam int CAP = 16;

  wr_t         sched[$];
  logic [32:0] mq[$];
  logic [32:0] got[$];
  logic [31:0] adc_hist [0:4095];
  int          cyc;
  int          checks;
  int          errors;
  logic [15:0] fc_m;
  bit          ovf_m;
  bit          miss_m;
  int          k;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs with the model, then advance the model.
  task automatic step();
    wr_t         e;
    logic [32:0] w;
    bit          idle, pop, wr, ev_ovf, ev_miss;
    int          n, sz;
    chk("busy", busy, sched.size() != 0);
    chk("tvalid", RX_0_tvalid, mq.size() != 0);
    if (mq.size() != 0) chk("head", {RX_0_tlast, RX_0_tdata}, mq[0]);
    else                chk("empty_word", {RX_0_tlast, RX_0_tdata}, 33'd0);
    chk("ovf", ovf, ovf_m);
    chk("trig_miss", trig_miss, miss_m);
    if (RX_0_tvalid && RX_0_tready) got.push_back({RX_0_tlast, RX_0_tdata});
    if (cyc < 4096) adc_hist[cyc] = adc_0;

    idle    = (sched.size() == 0);
    sz      = mq.size();
    pop     = (sz != 0) && RX_0_tready;
    wr      = 1'b0;
    w       = '0;
    ev_ovf  = 1'b0;
    ev_miss = 1'b0;
    if (!idle) begin
      e  = sched.pop_front();
      wr = 1'b1;
      w  = {e.last, (e.is_hdr ? e.dat : adc_0)};
    end
    if (pop) void'(mq.pop_front());
    if (wr) begin
      if (sz < CAP || pop) mq.push_back(w);
      else                 ev_ovf = 1'b1;
    end
    if (trig) begin
      if (idle) begin
        n = int'(rxsmps);
        sched.push_back('{is_hdr: 1'b1, last: (n == 0), dat: {fc_m, rxsmps}});
        for (int i = 0; i < n; i++)
          sched.push_back('{is_hdr: 1'b0, last: (i == n - 1), dat: 32'd0});
        fc_m++;
      end else begin
        ev_miss = 1'b1;
      end
    end
    ovf_m  = ev_ovf  ? 1'b1 : (clr ? 1'b0 : ovf_m);
    miss_m = ev_miss ? 1'b1 : (clr ? 1'b0 : miss_m);
    @(posedge ref_clk);
    @(negedge ref_clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      adc_0 = $urandom();
      step();
    end
  endtask

  // Asynchronous reset at an arbitrary point in the cycle; all outputs must drop at once.
  task automatic do_reset();
    ref_rstn = 1'b0;
    #1;
    chk("rst_tvalid", RX_0_tvalid, 1'b0);
    chk("rst_tlast", RX_0_tlast, 1'b0);
    chk("rst_tdata", RX_0_tdata, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_trig_miss", trig_miss, 1'b0);
    sched.delete();
    mq.delete();
    got.delete();
    fc_m   = '0;
    ovf_m  = 1'b0;
    miss_m = 1'b0;
    @(posedge ref_clk);
    @(posedge ref_clk);
    @(negedge ref_clk);
    ref_rstn = 1'b1;
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [32:0] exp);
    if (idx < got.size()) chk(tag, got[idx], exp);
    else                  chk({tag, "_missing"}, 33'd0, exp);
  endtask

  initial begin
    logic [32:0] eb [5];
    logic [32:0] pw;
    bit          stall;
    int          nl;
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    trig        = 1'b0;
    rxsmps      = '0;
    adc_0       = '0;
    clr         = 1'b0;
    RX_0_tready = 1'b1;
    do_reset();

    // Basic 4-sample frame with a ramp on the ADC.
    RX_0_tready = 1'b1;
    trig = 1'b1; rxsmps = 16'd4; adc_0 = $urandom();
    step();
    trig = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adc_0 = 32'h100 + i - 1;
      step();
    end
    eb = '{{1'b0, 32'h0000_0004}, {1'b0, 32'h100}, {1'b0, 32'h101},
           {1'b0, 32'h102}, {1'b1, 32'h103}};
    chk("ramp_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk_got("ramp_word", i, eb[i]);
    chk("ramp_ovf", ovf, 1'b0);

    // Zero-length frames: header only, frame counter advances.
    do_reset();
    trig = 1'b1; rxsmps = 16'd0; step(); trig = 1'b0;
    run(4);
    trig = 1'b1; step(); trig = 1'b0;
    run(4);
    chk("zero_count", got.size(), 2);
    chk_got("zero_first", 0, {1'b1, 32'h0000_0000});
    chk_got("zero_second", 1, {1'b1, 32'h0001_0000});

    // Overflow with a stalled consumer, then drain.
    do_reset();
    RX_0_tready = 1'b0;
    adc_0 = $urandom();
    k = cyc;
    trig = 1'b1; rxsmps = 16'd40; step(); trig = 1'b0;
    run(45);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_nothing_out", got.size(), 0);
    RX_0_tready = 1'b1;
    run(20);
    chk("ovf_drain_count", got.size(), 16);
    chk_got("ovf_hdr", 0, {1'b0, 32'h0000_0028});
    for (int i = 1; i < 16; i++) chk_got("ovf_sample", i, {1'b0, adc_hist[k + 1 + i]});

    // Trigger while busy is ignored and sticky; clear, and set-wins-over-clear.
    do_reset();
    RX_0_tready = 1'b1;
    trig = 1'b1; rxsmps = 16'd8; step(); trig = 1'b0;
    run(2);
    trig = 1'b1; step(); trig = 1'b0;
    run(12);
    chk("miss_set", trig_miss, 1'b1);
    chk("miss_frame_words", got.size(), 9);
    nl = 0;
    foreach (got[i]) if (got[i][32]) nl++;
    chk("miss_one_last", nl, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("miss_cleared", trig_miss, 1'b0);
    trig = 1'b1; rxsmps = 16'd3; step(); trig = 1'b0;
    step();
    trig = 1'b1; clr = 1'b1; step(); trig = 1'b0; clr = 1'b0;
    chk("miss_set_wins", trig_miss, 1'b1);
    run(8);

    // Alternating ready: no loss, order kept, head held while stalled.
    do_reset();
    RX_0_tready = 1'b1;
    adc_0 = $urandom();
    k = cyc;
    trig = 1'b1; rxsmps = 16'd20; step(); trig = 1'b0;
    stall = 1'b0;
    pw    = '0;
    for (int i = 0; i < 60; i++) begin
      RX_0_tready = (i % 2 == 0);
      adc_0 = $urandom();
      if (stall && RX_0_tvalid) chk("toggle_stable", {RX_0_tlast, RX_0_tdata}, pw);
      stall = RX_0_tvalid && !RX_0_tready;
      pw    = {RX_0_tlast, RX_0_tdata};
      step();
    end
    chk("toggle_ovf", ovf, 1'b0);
    chk("toggle_count", got.size(), 21);
    chk_got("toggle_hdr", 0, {1'b0, 32'h0000_0014});
    for (int i = 1; i <= 20; i++)
      chk_got("toggle_sample", i, {(i == 20), adc_hist[k + 1 + i]});

    // Reset in the middle of a capture, then a fresh frame restarts the counter.
    RX_0_tready = 1'b0;
    trig = 1'b1; rxsmps = 16'd10; step(); trig = 1'b0;
    run(5);
    chk("midrst_valid_before", RX_0_tvalid, 1'b1);
    do_reset();
    RX_0_tready = 1'b1;
    adc_0 = $urandom();
    k = cyc;
    trig = 1'b1; rxsmps = 16'd2; step(); trig = 1'b0;
    run(6);
    chk("midrst_count", got.size(), 3);
    chk_got("midrst_hdr", 0, {1'b0, 32'h0000_0002});
    chk_got("midrst_s0", 1, {1'b0, adc_hist[k + 2]});
    chk_got("midrst_s1", 2, {1'b1, adc_hist[k + 3]});

    // Random traffic: triggers, lengths, ready and clears all mixed.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      trig        = ($urandom_range(7) == 0);
      rxsmps      = 16'($urandom_range(12));
      RX_0_tready = ($urandom_range(3) != 0);
      clr         = ($urandom_range(15) == 0);
      adc_0       = $urandom();
      step();
    end
    trig = 1'b0; clr = 1'b0; RX_0_tready = 1'b1;
    run(40);
    chk("rand_drained", RX_0_tvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
